// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: framebuffer geometry and shared types for the VGA
// framebuffer arbiter (160x120 RGB332, 4x4 pixel replication).
package vga_fb_pkg;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int FB_SIZE    = FB_W * FB_H;
  localparam int SCALE_LOG2 = 2;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 15;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_fb_addr.sv
// vga_fb_addr: framebuffer x/y to linear address, y*160 + x.
// Ports: x (0..159), y (0..119) in; addr out. Shift-add, no multiplier.
module vga_fb_addr
  import vga_fb_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  output fb_addr_t   addr
);

  // 160 = 128 + 32
  assign addr = (fb_addr_t'(y) << 7)
              + (fb_addr_t'(y) << 5)
              + fb_addr_t'(x);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one sync-read frame RAM between scan-out,
// a clear engine and a pixel writer (priority in that order).
// Ports: clk/reset; col,row,visible,hsync_in,vsync_in from timing;
// wr_req/wr_addr/wr_data/wr_ack writer; clear_req/clear_color/
// clear_busy/clear_done clear engine; ram_* RAM port;
// pix_data,pix_visible,hsync_out,vsync_out to the DAC (2-cycle delay).
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic              visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_visible,
  output logic              hsync_out,
  output logic              vsync_out
);

  arb_state_t state;
  fb_addr_t   cnt;
  fb_addr_t   disp_addr;
  pixel_t     color;
  logic       done_q;
  logic       slot;
  logic       last;
  logic       wr_ok;

  logic       slot_d1;
  logic       vis_d1;
  logic       hs_d1;
  logic       vs_d1;
  pixel_t     hold;
  pixel_t     pix_q;
  logic       vis_q;
  logic       hs_q;
  logic       vs_q;

  logic       unused_row;
  assign unused_row = ^{row[9], row[1:0]};

  assign slot  = visible && (col[SCALE_LOG2-1:0] == '0);
  assign last  = (cnt == fb_addr_t'(FB_SIZE - 1));
  assign wr_ok = (wr_addr < fb_addr_t'(FB_SIZE));

  vga_fb_addr u_addr (
    .x    (col[9:2]),
    .y    (row[8:2]),
    .addr (disp_addr)
  );

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (slot) begin
      ram_addr = disp_addr;
    end else if (state == CLEAR) begin
      ram_addr  = cnt;
      ram_we    = 1'b1;
      ram_wdata = color;
    end else if (wr_req && !clear_req) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      ram_we    = wr_ok;
      wr_ack    = 1'b1;
    end
    // Nothing may touch the RAM while reset is held,
    // so an abandoned clear leaves no extra write behind.
    if (reset) begin
      ram_we = 1'b0;
      wr_ack = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      color  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
            color <= clear_color;
          end
        end
        CLEAR: begin
          if (!slot) begin
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Stage 1 sees the read data of the slot; the hold register
  // replays it for the next three columns of the 4-wide block.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_d1 <= 1'b0;
      vis_d1  <= 1'b0;
      hs_d1   <= 1'b1;
      vs_d1   <= 1'b1;
      hold    <= '0;
      pix_q   <= '0;
      vis_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      slot_d1 <= slot;
      vis_d1  <= visible;
      hs_d1   <= hsync_in;
      vs_d1   <= vsync_in;
      if (slot_d1) hold <= ram_rdata;
      pix_q   <= vis_d1 ? (slot_d1 ? ram_rdata : hold) : '0;
      vis_q   <= vis_d1;
      hs_q    <= hs_d1;
      vs_q    <= vs_d1;
    end
  end

  assign clear_busy  = (state == CLEAR);
  assign clear_done  = done_q;
  assign pix_data    = pix_q;
  assign pix_visible = vis_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;

endmodule
